dmem_access_unit: RTL and testbench

- CPU-side initiator for the 16-bit word-addressed data memory: takes byte-addressed load/store requests from the MEM pipeline stage.
- Drives the memory's write-enable, byte-enable, word address and write data, and samples its combinational read data.
- Handles byte and halfword accesses, splits misaligned halfwords into two word accesses, range-checks addresses and returns sign- or zero-extended load data through a valid/ready handshake.

---
 rtl/dmem_access_unit_pkg.sv | 24 ++
 rtl/dmem_load_align.sv | 21 ++
 rtl/dmem_access_unit.sv | 140 ++++++++++++++
 tb/tb_dmem_access_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: size codes, FSM states,
// byte-enable constants and the registered request record.
package dmem_access_unit_pkg;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_HALF = 1'b1;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_ALL  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic        size;
    logic        uns;
    logic        off;
    logic        mis;
    logic [15:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_load_align.sv
// Load-result extraction: picks the addressed byte or passes the halfword,
// then sign- or zero-extends a byte result.
module dmem_load_align
  import dmem_access_unit_pkg::*;
(
  input  logic [1:0][7:0] raw,
  input  logic            size,
  input  logic            offset,
  input  logic            uns,
  output logic [15:0]     data
);

  logic [7:0] b;

  always_comb begin
    b = offset ? raw[1] : raw[0];
    if (size == SZ_HALF) data = raw;
    else                 data = {{8{b[7] & ~uns}}, b};
  end

endmodule

// File: rtl/dmem_access_unit.sv
// CPU-side initiator for the 16-bit word-addressed data memory: byte/halfword
// loads and stores, misaligned halfword split, range check, valid/ready handshake.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  mem_wr_en,
  output logic [1:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int WW = ADDR_WIDTH - 1;

  state_t          state;
  req_t            r;
  logic [WW-1:0]   w0, w1;
  logic [7:0]      lo_q;
  logic [WW-1:0]   in_w0, in_w1;
  logic            in_mis, in_err;
  logic [15:0]     raw, ld_data;

  assign in_w0  = req_addr[ADDR_WIDTH-1:1];
  assign in_w1  = in_w0 + WW'(1);
  assign in_mis = (req_size == SZ_HALF) && req_addr[0];
  assign in_err = (int'(in_w0) >= MEM_SIZE) || (in_mis && (int'(in_w1) >= MEM_SIZE));

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);

  // Second half of a misaligned load: high byte from W1, low byte saved from W0.
  assign raw = (state == ACC1) ? {mem_rd_data[7:0], lo_q} : mem_rd_data;

  dmem_load_align u_align (
    .raw    (raw),
    .size   (r.size),
    .offset (r.off),
    .uns    (r.uns),
    .data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      r          <= '0;
      w0         <= '0;
      w1         <= '0;
      lo_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_rdata <= '0;
          resp_err   <= req_valid & in_err;
          if (req_valid) begin
            r     <= '{we: req_we, size: req_size, uns: req_unsigned, off: req_addr[0],
                       mis: in_mis, wdata: req_wdata};
            w0    <= in_w0;
            w1    <= in_w1;
            state <= in_err ? DONE : ACC0;
          end
        end
        ACC0: begin
          lo_q <= mem_rd_data[15:8];
          if (r.mis) state <= ACC1;
          else begin
            state <= DONE;
            if (!r.we) resp_rdata <= ld_data;
          end
        end
        ACC1: begin
          state <= DONE;
          if (!r.we) resp_rdata <= ld_data;
        end
        default: begin
          state      <= IDLE;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

  // Write-lane steering; everything forced low during reset so no write lands on a reset edge.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_be      = BE_NONE;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (!rst) begin
      case (state)
        ACC0: begin
          mem_addr = {1'b0, w0};
          if (r.we) begin
            mem_wr_en = 1'b1;
            if (r.size == SZ_BYTE) begin
              mem_be      = r.off ? BE_HI : BE_LO;
              mem_wr_data = {r.wdata[7:0], r.wdata[7:0]};
            end else if (r.mis) begin
              mem_be      = BE_HI;
              mem_wr_data = {r.wdata[7:0], 8'h00};
            end else begin
              mem_be      = BE_ALL;
              mem_wr_data = r.wdata;
            end
          end
        end
        ACC1: begin
          mem_addr = {1'b0, w1};
          if (r.we) begin
            mem_wr_en   = 1'b1;
            mem_be      = BE_LO;
            mem_wr_data = {8'h00, r.wdata[15:8]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: table of request vectors with a
// memory model and response scoreboard, plus handshake and mid-op reset sequences.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_size, req_unsigned;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, busy, mem_wr_en;
  logic [15:0] resp_rdata, mem_addr, mem_wr_data, mem_rd_data;
  logic [1:0]  mem_be;

  always #5 clk = ~clk;

  dmem_access_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_SIZE(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .mem_wr_en(mem_wr_en), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // Memory model: combinational read, byte-enabled write on the rising edge.
  bit [15:0] mem [256];
  assign mem_rd_data = mem[mem_addr[7:0]];
  always @(posedge clk)
    if (mem_wr_en) begin
      if (mem_be[0]) mem[mem_addr[7:0]][7:0]  <= mem_wr_data[7:0];
      if (mem_be[1]) mem[mem_addr[7:0]][15:8] <= mem_wr_data[15:8];
    end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit we, size, uns;
    logic [15:0] addr, wdata, rdata;
    bit err;
    int lat, nwr;
    logic [15:0] a0; logic [1:0] be0; logic [15:0] wd0;
    logic [15:0] a1; logic [1:0] be1; logic [15:0] wd1;
  } vec_t;

  typedef struct { logic [15:0] rdata; logic err; } exp_t;
  exp_t sbq[$];

  function automatic vec_t mk(bit we, bit size, bit uns, logic [15:0] addr, logic [15:0] wdata,
                              logic [15:0] rdata, bit err, int lat, int nwr,
                              logic [15:0] a0, logic [1:0] be0, logic [15:0] wd0,
                              logic [15:0] a1, logic [1:0] be1, logic [15:0] wd1);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat; v.nwr = nwr;
    v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
    return v;
  endfunction

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_unexpected_resp"}, 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_rdata"}, resp_rdata, e.rdata);
    chk({tag, "_err"}, resp_err, e.err);
  endtask

  task automatic do_vec(input vec_t v, input string tag);
    int n, nwr, waitc;
    bit got;
    logic [15:0] a [2];
    logic [1:0]  be [2];
    logic [15:0] wd [2];
    @(negedge clk);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    waitc = 0;
    while (!req_ready && waitc < 20) begin @(negedge clk); waitc++; end
    if (!req_ready) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      req_valid = 1'b0;
      return;
    end
    sbq.push_back('{v.rdata, v.err});
    @(negedge clk);
    req_valid = 1'b0;
    n = 1; nwr = 0; got = 0;
    while (n <= 6) begin
      if (n <= 2) begin a[n-1] = mem_addr; be[n-1] = mem_be; wd[n-1] = mem_wr_data; end
      if (mem_wr_en) nwr++;
      if (resp_valid) begin got = 1; break; end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, got ? n : 0, v.lat);
    if (got) pop_cmp(tag);
    else sbq.delete();
    chk({tag, "_nwrites"}, nwr, v.nwr);
    if (!v.err) begin
      chk({tag, "_acc0_addr"}, a[0], v.a0);
      chk({tag, "_acc0_be"}, be[0], v.be0);
      chk({tag, "_acc0_wdata"}, wd[0], v.wd0);
    end
    if (v.lat == 3) begin
      chk({tag, "_acc1_addr"}, a[1], v.a1);
      chk({tag, "_acc1_be"}, be[1], v.be1);
      chk({tag, "_acc1_wdata"}, wd[1], v.wd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int acc, nresp;

    // Reset state, with a store request held to show nothing leaks through.
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1; req_unsigned = 1'b0;
    req_addr = 16'h0010; req_wdata = 16'hFFFF;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    req_valid = 1'b0;
    rst = 1'b0;

    //             we sz un addr     wdata    rdata    err lat nwr a0       be0    wd0      a1       be1    wd1
    tbl.push_back(mk(1, 1, 0, 16'h0020, 16'h80FF, 16'h0000, 0, 2, 1, 16'h0010, 2'b11, 16'h80FF, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0010, 16'hBEEF, 16'h0000, 0, 2, 1, 16'h0008, 2'b11, 16'hBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 2, 0, 16'h0008, 2'b00, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0011, 16'h0000, 16'hFFBE, 0, 2, 0, 16'h0008, 2'b00, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0011, 16'h0000, 16'h00BE, 0, 2, 0, 16'h0008, 2'b00, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0021, 16'h0000, 16'hFF80, 0, 2, 0, 16'h0010, 2'b00, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0021, 16'hAB7A, 16'h0000, 0, 2, 1, 16'h0010, 2'b10, 16'h7A7A, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0021, 16'h0000, 16'h007A, 0, 2, 0, 16'h0010, 2'b00, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0020, 16'h0000, 16'h00FF, 0, 2, 0, 16'h0010, 2'b00, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0020, 16'h0000, 16'hFFFF, 0, 2, 0, 16'h0010, 2'b00, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0020, 16'h0055, 16'h0000, 0, 2, 1, 16'h0010, 2'b01, 16'h5555, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0020, 16'h0000, 16'h7A55, 0, 2, 0, 16'h0010, 2'b00, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0031, 16'h1234, 16'h0000, 0, 3, 2, 16'h0018, 2'b10, 16'h3400, 16'h0019, 2'b01, 16'h0012));
    tbl.push_back(mk(0, 1, 0, 16'h0031, 16'h0000, 16'h1234, 0, 3, 0, 16'h0018, 2'b00, 16'h0000, 16'h0019, 2'b00, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0030, 16'h0000, 16'h3400, 0, 2, 0, 16'h0018, 2'b00, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0032, 16'h0000, 16'h0012, 0, 2, 0, 16'h0019, 2'b00, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0200, 16'hCAFE, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h01FF, 16'h0000, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h01FF, 16'h0000, 16'h0000, 0, 2, 0, 16'h00FF, 2'b00, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h01FE, 16'h1111, 16'h0000, 0, 2, 1, 16'h00FF, 2'b01, 16'h1111, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h01FE, 16'h0000, 16'h0011, 0, 2, 0, 16'h00FF, 2'b00, 16'h0000, 0, 0, 0));

    foreach (tbl[i]) do_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back aligned loads with req_valid held high: accepts every 3 cycles.
    @(negedge clk);
    req_we = 1'b0; req_size = 1'b1; req_unsigned = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
    acc = 0; nresp = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (acc == 3) req_valid = 1'b0;
      chk("b2b_busy", busy, !req_ready);
      if (resp_valid) begin pop_cmp("b2b"); nresp++; end
      if (req_valid && req_ready) begin
        chk("b2b_accept_cycle", cyc, 3 * acc);
        sbq.push_back('{16'hBEEF, 1'b0});
        acc++;
      end
      @(negedge clk);
    end
    chk("b2b_accepts", acc, 3);
    chk("b2b_responses", nresp, 3);

    // Reset during ACC1 of a misaligned store: W0 high byte committed, W1 untouched.
    do_vec(mk(1, 1, 0, 16'h0040, 16'h5566, 0, 0, 2, 1, 16'h0020, 2'b11, 16'h5566, 0, 0, 0), "pre0");
    do_vec(mk(1, 1, 0, 16'h0042, 16'h7788, 0, 0, 2, 1, 16'h0021, 2'b11, 16'h7788, 0, 0, 0), "pre1");
    @(negedge clk);
    req_we = 1'b1; req_size = 1'b1; req_addr = 16'h0041; req_wdata = 16'hAABB; req_valid = 1'b1;
    chk("mrst_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mrst_acc0_be", mem_be, 2'b10);
    chk("mrst_acc0_wdata", mem_wr_data, 16'hBB00);
    @(negedge clk);
    chk("mrst_acc1_wr_en", mem_wr_en, 1);
    rst = 1'b1;
    #1;
    chk("mrst_gated_wr_en", mem_wr_en, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_no_resp", resp_valid, 0);
    @(negedge clk);
    chk("mrst_idle_ready", req_ready, 1);
    chk("mrst_idle_busy", busy, 0);
    chk("mrst_no_resp2", resp_valid, 0);
    chk("mrst_w0", mem[8'h20], 16'hBB66);
    chk("mrst_w1", mem[8'h21], 16'h7788);
    do_vec(mk(0, 1, 0, 16'h0040, 0, 16'hBB66, 0, 2, 0, 16'h0020, 2'b00, 16'h0000, 0, 0, 0), "post0");

    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
